// File: rtl/wasm_bulk_mem_engine_if.sv
// wasm_bulk_mem_engine_if: memory bus types plus the request/response bundle between engine and linear memory
// Package wasm_bulk_mem_pkg: page size, access size, load op, trap codes, bus request/response structs.
// Interface ports: mem_req_o, mem_op_o (engine -> memory); mem_resp_i (memory -> engine).
package wasm_bulk_mem_pkg;
    localparam int unsigned PAGE_SIZE = 65536;
    typedef enum logic [1:0] {MEM_SIZE_1, MEM_SIZE_2, MEM_SIZE_4, MEM_SIZE_8} mem_size_t;
    typedef enum logic [2:0] {
        MEM_LOAD_I8_S, MEM_LOAD_I8_U, MEM_LOAD_I16_S, MEM_LOAD_I16_U,
        MEM_LOAD_I32_S, MEM_LOAD_I32_U, MEM_LOAD_I64
    } mem_op_t;
    typedef enum logic [1:0] {TRAP_NONE, TRAP_OUT_OF_BOUNDS, TRAP_UNREACHABLE} trap_t;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [63:0] wdata;
        mem_size_t   size;
    } mem_bus_req_t;
    typedef struct packed {
        logic        ready;
        logic [63:0] rdata;
        logic        rvalid;
        logic        error;
    } mem_bus_resp_t;
endpackage

interface wasm_bulk_mem_engine_if;
    import wasm_bulk_mem_pkg::*;
    mem_bus_req_t  mem_req_o;
    mem_op_t       mem_op_o;
    mem_bus_resp_t mem_resp_i;
    modport master (output mem_req_o, output mem_op_o, input mem_resp_i);
    modport slave  (input mem_req_o, input mem_op_o, output mem_resp_i);
endinterface

// File: rtl/wasm_bulk_mem_engine.sv
// wasm_bulk_mem_engine: sequencer for wasm memory.fill / memory.copy with up-front bounds check
// Ports: clk, rst (sync, active-high); start/op_copy/dst_i/src_i/val_i/len_i/cur_pages_i command inputs;
// bus (master modport: byte read/write requests and responses); busy, done pulse, trap_o result code.
module wasm_bulk_mem_engine
    import wasm_bulk_mem_pkg::*;
#(
    parameter int unsigned PAGE_BYTES = PAGE_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op_copy,
    input  logic [31:0]            dst_i,
    input  logic [31:0]            src_i,
    input  logic [7:0]             val_i,
    input  logic [31:0]            len_i,
    input  logic [31:0]            cur_pages_i,
    wasm_bulk_mem_engine_if.master bus,
    output logic                   busy,
    output logic                   done,
    output trap_t                  trap_o
);
    typedef enum logic [2:0] {IDLE, CHECK, RD, WR, FIN} state_t;
    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic        back_q, back_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] src_q, src_d;
    logic [31:0] rem_q, rem_d;
    logic [7:0]  byte_q, byte_d;
    trap_t       trap_q, trap_d;
    logic [32:0] limit, dend, send;
    logic        oob, backward;
    logic [31:0] step;
    logic        unused_rdata;

    // 33-bit ends so a range ending exactly at 2^32 is still representable
    assign limit = 33'(cur_pages_i) * 33'(PAGE_BYTES);
    assign dend = {1'b0, dst_q} + {1'b0, rem_q};
    assign send = {1'b0, src_q} + {1'b0, rem_q};
    assign oob = (dend > limit) || (op_q && send > limit);
    // dst inside (src, src+len): a forward walk would clobber unread source bytes
    assign backward = op_q && (dst_q > src_q) && ({1'b0, dst_q} < send);
    assign step = back_q ? 32'hFFFF_FFFF : 32'd1;
    assign busy = state_q != IDLE;
    assign unused_rdata = ^bus.mem_resp_i.rdata[63:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            back_q  <= 1'b0;
            dst_q   <= '0;
            src_q   <= '0;
            rem_q   <= '0;
            byte_q  <= '0;
            trap_q  <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            back_q  <= back_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        back_d = back_q;
        dst_d = dst_q;
        src_d = src_q;
        rem_d = rem_q;
        byte_d = byte_q;
        trap_d = trap_q;
        bus.mem_req_o = '0;
        bus.mem_op_o = MEM_LOAD_I8_U;
        done = 1'b0;
        trap_o = TRAP_NONE;
        case (state_q)
            IDLE: if (start) begin
                op_d = op_copy;
                dst_d = dst_i;
                src_d = src_i;
                rem_d = len_i;
                byte_d = val_i;
                back_d = 1'b0;
                trap_d = TRAP_NONE;
                state_d = CHECK;
            end
            CHECK: begin
                if (oob) begin
                    trap_d = TRAP_OUT_OF_BOUNDS;
                    state_d = FIN;
                end else if (rem_q == '0) begin
                    state_d = FIN;
                end else begin
                    if (backward) begin
                        dst_d = dst_q + rem_q - 32'd1;
                        src_d = src_q + rem_q - 32'd1;
                        back_d = 1'b1;
                    end
                    state_d = op_q ? RD : WR;
                end
            end
            RD: begin
                bus.mem_req_o.valid = 1'b1;
                bus.mem_req_o.addr = src_q;
                bus.mem_req_o.size = MEM_SIZE_1;
                if (bus.mem_resp_i.ready && bus.mem_resp_i.rvalid) begin
                    byte_d = bus.mem_resp_i.rdata[7:0];
                    state_d = WR;
                end else if (bus.mem_resp_i.ready && bus.mem_resp_i.error) begin
                    trap_d = TRAP_OUT_OF_BOUNDS;
                    state_d = FIN;
                end
            end
            WR: begin
                bus.mem_req_o.valid = 1'b1;
                bus.mem_req_o.write = 1'b1;
                bus.mem_req_o.addr = dst_q;
                bus.mem_req_o.wdata = {56'b0, byte_q};
                bus.mem_req_o.size = MEM_SIZE_1;
                if (bus.mem_resp_i.ready && bus.mem_resp_i.error) begin
                    trap_d = TRAP_OUT_OF_BOUNDS;
                    state_d = FIN;
                end else if (bus.mem_resp_i.ready) begin
                    rem_d = rem_q - 32'd1;
                    dst_d = dst_q + step;
                    src_d = src_q + step;
                    state_d = (rem_q == 32'd1) ? FIN : (op_q ? RD : WR);
                end
            end
            FIN: begin
                done = 1'b1;
                trap_o = trap_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_wasm_bulk_mem_engine.sv
// tb_wasm_bulk_mem_engine: table-driven and directed checks of fill/copy sequencing, bounds, backpressure, error and reset
module tb_wasm_bulk_mem_engine;
    import wasm_bulk_mem_pkg::*;

    typedef struct {
        logic        op;
        logic [31:0] dst;
        logic [31:0] src;
        logic [7:0]  val;
        logic [31:0] len;
        logic [31:0] pages;
        trap_t       trap;
        int          dcyc;
        int          nreq;
        logic [7:0]  chk_a;
        logic [31:0] chk_w;
        logic [31:0] first_wa;
        logic [31:0] last_wa;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic op_copy = 1'b0;
    logic [31:0] dst = '0;
    logic [31:0] src = '0;
    logic [7:0] val = '0;
    logic [31:0] len = '0;
    logic [31:0] pages = '0;
    logic busy, done;
    trap_t trap;

    logic rdy = 1'b1;
    logic rand_rdy = 1'b0;
    logic clr = 1'b1;
    int err_at = -1;
    logic [7:0] mem [256];
    int nreq, nwr, unstable;
    logic [31:0] first_wa, last_wa;
    logic stall_q = 1'b0;
    mem_bus_req_t prev_req;
    int pass = 0;
    int total = 0;
    vec_t vecs [10];

    wasm_bulk_mem_engine_if bus ();

    wasm_bulk_mem_engine dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op_copy(op_copy),
        .dst_i(dst),
        .src_i(src),
        .val_i(val),
        .len_i(len),
        .cur_pages_i(pages),
        .bus(bus),
        .busy(busy),
        .done(done),
        .trap_o(trap)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.mem_resp_i = '0;
        bus.mem_resp_i.ready = rdy;
        bus.mem_resp_i.rdata = {56'b0, mem[bus.mem_req_o.addr[7:0]]};
        bus.mem_resp_i.rvalid = bus.mem_req_o.valid && !bus.mem_req_o.write && rdy;
        bus.mem_resp_i.error = bus.mem_req_o.valid && bus.mem_req_o.write && rdy && (nwr == err_at);
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            nreq <= 0;
            nwr <= 0;
            unstable <= 0;
            first_wa <= '0;
            last_wa <= '0;
        end else begin
            if (bus.mem_req_o.valid && rdy) begin
                nreq <= nreq + 1;
                if (bus.mem_req_o.write) begin
                    nwr <= nwr + 1;
                    if (!bus.mem_resp_i.error) begin
                        mem[bus.mem_req_o.addr[7:0]] <= bus.mem_req_o.wdata[7:0];
                        if (nwr == 0) first_wa <= bus.mem_req_o.addr;
                        last_wa <= bus.mem_req_o.addr;
                    end
                end
            end
            if (stall_q && !rst && bus.mem_req_o != prev_req) unstable <= unstable + 1;
        end
        stall_q <= bus.mem_req_o.valid && !rdy && !rst;
        prev_req <= bus.mem_req_o;
    end

    initial begin
        forever begin
            @(negedge clk);
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic logic [31:0] word_at(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic clear_mem();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_op(input vec_t v, output int dcyc, output int busy_bad, output trap_t tr);
        op_copy = v.op;
        dst = v.dst;
        src = v.src;
        val = v.val;
        len = v.len;
        pages = v.pages;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcyc = -1;
        busy_bad = 0;
        tr = TRAP_UNREACHABLE;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (!busy) busy_bad++;
            if (done) begin
                dcyc = n;
                tr = trap;
                break;
            end
        end
    endtask

    initial begin
        int dc, bb, cnt;
        trap_t tr;
        vec_t v;
        vecs[0] = '{1'b0, 32'h10, 32'h0, 8'hA5, 32'd4, 32'd1, TRAP_NONE, 6, 4, 8'h10, 32'hA5A5A5A5, 32'h10, 32'h13};
        vecs[1] = '{1'b0, 32'hFFFF, 32'h0, 8'h11, 32'd2, 32'd1, TRAP_OUT_OF_BOUNDS, 2, 0, 8'h00, 32'h03020100, 32'h0, 32'h0};
        vecs[2] = '{1'b1, 32'h0, 32'h10000, 8'h00, 32'd0, 32'd1, TRAP_NONE, 2, 0, 8'h00, 32'h03020100, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 32'h0, 32'h10001, 8'h00, 32'd0, 32'd1, TRAP_OUT_OF_BOUNDS, 2, 0, 8'h00, 32'h03020100, 32'h0, 32'h0};
        vecs[4] = '{1'b0, 32'h0, 32'h0, 8'h00, 32'd0, 32'd0, TRAP_NONE, 2, 0, 8'h00, 32'h03020100, 32'h0, 32'h0};
        vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'h0, 8'h22, 32'd2, 32'd65536, TRAP_OUT_OF_BOUNDS, 2, 0, 8'h00, 32'h03020100, 32'h0, 32'h0};
        vecs[6] = '{1'b1, 32'h2, 32'h0, 8'h00, 32'd4, 32'd1, TRAP_NONE, 10, 8, 8'h02, 32'h03020100, 32'h5, 32'h2};
        vecs[7] = '{1'b1, 32'h0, 32'h2, 8'h00, 32'd4, 32'd1, TRAP_NONE, 10, 8, 8'h00, 32'h05040302, 32'h0, 32'h3};
        vecs[8] = '{1'b0, 32'hFFFE, 32'h0, 8'h5A, 32'd2, 32'd1, TRAP_NONE, 4, 2, 8'hFC, 32'h5A5AFDFC, 32'hFFFE, 32'hFFFF};
        vecs[9] = '{1'b1, 32'h20, 32'hFFFF, 8'h00, 32'd2, 32'd1, TRAP_OUT_OF_BOUNDS, 2, 0, 8'h00, 32'h03020100, 32'h0, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset trap", trap, TRAP_NONE);
        check("reset valid", bus.mem_req_o.valid, 0);
        check("reset memop", bus.mem_op_o, MEM_LOAD_I8_U);

        for (int i = 0; i < 10; i++) begin
            clear_mem();
            run_op(vecs[i], dc, bb, tr);
            check($sformatf("v%0d trap", i), tr, vecs[i].trap);
            check($sformatf("v%0d done_cycle", i), dc, vecs[i].dcyc);
            check($sformatf("v%0d busy_low_cycles", i), bb, 0);
            check($sformatf("v%0d requests", i), nreq, vecs[i].nreq);
            check($sformatf("v%0d mem_word", i), word_at(vecs[i].chk_a), vecs[i].chk_w);
            if (vecs[i].nreq != 0) begin
                check($sformatf("v%0d first_waddr", i), first_wa, vecs[i].first_wa);
                check($sformatf("v%0d last_waddr", i), last_wa, vecs[i].last_wa);
            end
            @(negedge clk);
            check($sformatf("v%0d done_cleared", i), done, 0);
        end

        // backpressure: random ready during a 3-byte copy
        clear_mem();
        rand_rdy = 1'b1;
        v = '{1'b1, 32'h40, 32'h10, 8'h00, 32'd3, 32'd1, TRAP_NONE, 0, 6, 8'h40, 32'h43121110, 32'h40, 32'h42};
        run_op(v, dc, bb, tr);
        rand_rdy = 1'b0;
        check("bp trap", tr, TRAP_NONE);
        check("bp finished", dc > 0, 1);
        check("bp requests", nreq, 6);
        check("bp stable", unstable, 0);
        check("bp mem_word", word_at(8'h40), 32'h43121110);

        // write error on the 2nd write aborts the copy
        clear_mem();
        err_at = 1;
        run_op(v, dc, bb, tr);
        err_at = -1;
        check("err trap", tr, TRAP_OUT_OF_BOUNDS);
        check("err done_cycle", dc, 6);
        check("err requests", nreq, 4);
        check("err mem_word", word_at(8'h40), 32'h43424110);

        // reset during the 3rd write of an 8-byte fill
        clear_mem();
        op_copy = 1'b0;
        dst = 32'h80;
        val = 8'h77;
        len = 32'd8;
        pages = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (nwr == 2) break;
        end
        check("rst 3rd write presented", bus.mem_req_o.valid && bus.mem_req_o.write, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst valid", bus.mem_req_o.valid, 0);
        check("rst busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("rst no_done", cnt, 0);
        v = '{1'b0, 32'h90, 32'h0, 8'h3C, 32'd2, 32'd1, TRAP_NONE, 4, 2, 8'h90, 32'h93923C3C, 32'h90, 32'h91};
        run_op(v, dc, bb, tr);
        check("post_rst trap", tr, TRAP_NONE);
        check("post_rst done_cycle", dc, 4);
        check("post_rst mem_word", word_at(8'h90), 32'h93923C3C);

        // start held in the done cycle is ignored, accepted one cycle later
        clear_mem();
        v = '{1'b0, 32'hA0, 32'h0, 8'h11, 32'd1, 32'd1, TRAP_NONE, 3, 1, 8'hA0, 32'h0, 32'hA0, 32'hA0};
        run_op(v, dc, bb, tr);
        check("b2b first done_cycle", dc, 3);
        dst = 32'hA1;
        val = 8'h22;
        start = 1'b1;
        @(negedge clk);
        check("b2b ignored busy", busy, 0);
        @(negedge clk);
        check("b2b accepted busy", busy, 1);
        start = 1'b0;
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (done) begin
                cnt = 1;
                break;
            end
            @(negedge clk);
        end
        check("b2b second done", cnt, 1);
        check("b2b mem_a0", mem[8'hA0], 8'h11);
        check("b2b mem_a1", mem[8'hA1], 8'h22);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/wasm_bulk_mem_engine.md
# wasm_bulk_mem_engine

Sequencer for the WebAssembly bulk-memory instructions `memory.fill` and `memory.copy`. It sits directly upstream of the linear memory and drives the same memory bus request/response pair the execute stage uses. The bus mux arbitration lives outside this block; while `busy` is high the engine owns the port. The engine performs the up-front wasm bounds check, then emits byte-granular read/write requests, including correct direction selection for overlapping copies.

## Interface
- `PAGE_BYTES`, default `PAGE_SIZE` (65536), is the wasm page size used for the bounds check.
- `clk`  in  1  is the single clock.
- `rst`  in  1  is the reset. Reset is synchronous and active-high.
- `start`  in  1  requests an operation. It is sampled only in IDLE.
- `op_copy`  in  1  selects the operation: 0 = `memory.fill`, 1 = `memory.copy`.
- `dst_i`  in  32  is the destination byte address.
- `src_i`  in  32  is the source byte address (copy only).
- `val_i`  in  8  is the fill byte (fill only).
- `len_i`  in  32  is the byte count.
- `cur_pages_i`  in  32  is the current memory size in pages, from the memory management response.
- `mem_req_o`  out  `mem_bus_req_t`  is the bus request: valid, write, addr, wdata, size.
- `mem_op_o`  out  `mem_op_t`  carries the load type presented with reads.
- `mem_resp_i`  in  `mem_bus_resp_t`  is the bus response: ready, rdata, rvalid, error.
- `busy`  out  1  is high from the cycle after `start` is accepted through the `done` cycle.
- `done`  out  1  is a one-cycle completion pulse.
- `trap_o`  out  `trap_t`  is the result code. It is valid only while `done` is high and is `TRAP_NONE` otherwise.

## Operation
- States are IDLE, CHECK, RD, WR, FIN.
- **IDLE.** On `start`, latch dst, src, val, len and op, and go to CHECK. `start` is ignored in every other state.
- **CHECK** (one cycle):
  - Compute `limit = 33'(cur_pages_i) * PAGE_BYTES`.
  - Compute `dend = {1'b0,dst} + len` and `send = {1'b0,src} + len`, both 33-bit.
  - OOB is `dend > limit`, or for copy, `send > limit`.
  - If OOB: set trap to `TRAP_OUT_OF_BOUNDS` and go to FIN. No bus request is ever issued, so memory is untouched.
  - If len == 0 and not OOB: go to FIN with `TRAP_NONE`. A zero-length access at exactly `limit` is legal.
  - Copy direction is backward iff `dst > src` and `dst < src + len` (33-bit compare). Backward copies start with the cursors at dst+len-1 and src+len-1 and decrement. All other copies, and fill, start at dst/src and increment.
  - After CHECK, copy goes to RD and fill goes to WR.
- **RD** (copy only):
  - Drive valid=1, write=0, addr = src cursor, size = `MEM_SIZE_1`, and `mem_op_o = MEM_LOAD_I8_U`.
  - When `ready && rvalid`: latch `rdata[7:0]` and go to WR.
  - When `ready && error`: go to FIN with `TRAP_OUT_OF_BOUNDS`.
- **WR**:
  - Drive valid=1, write=1, addr = dst cursor, size = `MEM_SIZE_1`. wdata = {56'b0, byte}, where byte is the latched byte for copy and `val_i` (latched) for fill.
  - When `ready`, if `error` is set, go to FIN with `TRAP_OUT_OF_BOUNDS`.
  - When `ready` without error: decrement remaining and step the cursors. If remaining reaches 0, go to FIN; otherwise go to RD (copy) or stay in WR (fill).
- **FIN.** Assert `done`, present `trap_o`, and go to IDLE next cycle.
- **Idle bus.** Outside RD and WR, `mem_req_o` is all-zero (valid=0) and `mem_op_o` is `MEM_LOAD_I8_U`.
- **Cursor arithmetic.** Cursors are 32-bit and remaining is 32-bit. Cursors never wrap, because CHECK guarantees every touched address is below 2^32.

## Timing
- **Reset.** `rst` high at a clock edge forces IDLE on the next cycle, with busy=0, done=0, trap_o=`TRAP_NONE`, mem_req_o.valid=0 and cleared latches. Reset mid-operation abandons the operation: no further requests are issued and no `done` pulse occurs. Bytes already written remain written.
- **Handshake.** A request is held stable (addr, wdata, write, size) until the cycle in which `ready` is high. A write is consumed in the cycle `valid && write && ready` is high. Read data is taken combinationally in the same cycle.
- **Latency, with `ready` tied to 1 and `start` accepted at cycle 0.**
  - CHECK is in cycle 1.
  - Fill: writes occur in cycles 2..N+1, and `done` is in cycle N+2.
  - Copy: reads and writes alternate in cycles 2..2N+1, and `done` is in cycle 2N+2.
  - OOB or len==0: `done` is in cycle 2.
- **Back-to-back operation.** `start` asserted in the `done` cycle is ignored, because the engine is still in FIN. `start` in the following cycle is accepted.
- **Operand sampling.** `cur_pages_i` is sampled only in CHECK. A concurrent `memory.grow` does not affect an operation already past CHECK.

## Test plan
- **Fill.** `cur_pages`=1, fill dst=0x10, val=0xA5, len=4 → exactly 4 write requests to 0x10..0x13 with wdata=0xA5; `done` in cycle 6; trap `TRAP_NONE`; busy high in cycles 1–6.
- **Backward overlapping copy.** Memory [0..7]=00..07, copy dst=2, src=0, len=4 → writes issued in order 5,4,3,2; final [2..5]=00,01,02,03.
- **Forward overlapping copy.** Same initial memory, copy dst=0, src=2, len=4 → ascending order; final [0..3]=02,03,04,05.
- **Bounds.**
  - 1 page, fill dst=0xFFFF, len=2 → `done` in cycle 2 with `TRAP_OUT_OF_BOUNDS` and zero bus requests.
  - 1 page, copy src=0x10000, len=0 → `TRAP_NONE`.
  - 1 page, copy src=0x10001, len=0 → `TRAP_OUT_OF_BOUNDS`.
  - 0 pages, dst=0, len=0 → `TRAP_NONE`.
  - dst=0xFFFFFFFF, len=2 → OOB via 33-bit end.
- **Backpressure and error.** `ready` toggled 0/1 randomly during a copy of len=3 → requests stay stable while ready=0, and the result matches the ideal copy. Injecting `error` on the 2nd write → `done` with `TRAP_OUT_OF_BOUNDS` and no 3rd request.
- **Reset mid-operation.** Reset asserted during the 3rd write of a fill with len=8 → valid=0 and busy=0 the next cycle, no `done` pulse, and a new `start` afterwards completes normally.
